// File: rtl/fetch_decode_if.sv
// fetch_decode_if
//   Bundles the fetch-side inputs and decode-side outputs of the IF/ID latch.
//   Signals:
//     enable, stall, flush            control from debug unit / hazard unit
//     instruction_address, instruction fetch stage word address and data
//     id_instruction, id_npc, id_valid decode stage payload
//     halted, pc_freeze               sticky halt status for the debug unit
//     cycle_count, instr_count        debug counters
//   Handshake: there is no ready. The latch presents a new id_* payload on
//   every rising edge. id_valid qualifies id_instruction/id_npc as a real
//   fetched instruction. stall is the only backpressure, and it holds the
//   payload in place.
//   Modports: master = fetch/debug side (test driver); slave = the latch.
interface fetch_decode_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 enable;
  logic                 stall;
  logic                 flush;
  logic [31:0]          instruction_address;
  logic [31:0]          instruction;
  logic [31:0]          id_instruction;
  logic [31:0]          id_npc;
  logic                 id_valid;
  logic                 halted;
  logic                 pc_freeze;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output enable, stall, flush, instruction_address, instruction,
    input  id_instruction, id_npc, id_valid, halted, pc_freeze,
           cycle_count, instr_count
  );

  modport slave (
    input  enable, stall, flush, instruction_address, instruction,
    output id_instruction, id_npc, id_valid, halted, pc_freeze,
           cycle_count, instr_count
  );
endinterface

// File: rtl/fetch_decode_latch.sv
// fetch_decode_latch
//   IF/ID pipeline register. It captures the fetched word and its word-address
//   successor, and it handles stall hold, flush bubbles, the debug enable gate
//   and HALT detection. It also keeps cycle and instruction counters.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high
//     bus    fetch_decode_if.slave (see the interface for the signal list)
//   Update priority on each edge: reset > enable=0 > halted > flush > stall > load.
//   Every output is a register. pc_freeze is a copy of the halted register.
module fetch_decode_latch #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  fetch_decode_if.slave        bus
);

  logic [31:0]          id_instruction;
  logic [31:0]          id_npc;
  logic                 id_valid;
  logic                 halted;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      id_instruction <= NOP_WORD;
      id_npc         <= '0;
      id_valid       <= 1'b0;
      halted         <= 1'b0;
      cycle_count    <= '0;
      instr_count    <= '0;
    end else if (!bus.enable) begin
      // Debug freeze: every register, including the counters, holds.
    end else if (halted) begin
      // After a halt, emit bubbles. id_npc keeps the successor of the HALT word.
      id_instruction <= NOP_WORD;
      id_valid       <= 1'b0;
    end else begin
      // This also counts the edge that latches HALT, because halted was still 0.
      cycle_count <= cycle_count + 1'b1;
      if (bus.flush) begin
        // A flush squashes whatever is being fetched, including a HALT word.
        id_instruction <= NOP_WORD;
        id_npc         <= '0;
        id_valid       <= 1'b0;
      end else if (!bus.stall) begin
        id_instruction <= bus.instruction;
        id_npc         <= bus.instruction_address + 32'd1;
        id_valid       <= 1'b1;
        instr_count    <= instr_count + 1'b1;
        if (bus.instruction == HALT_WORD) begin
          halted <= 1'b1;
        end
      end
    end
  end

  assign bus.id_instruction = id_instruction;
  assign bus.id_npc         = id_npc;
  assign bus.id_valid       = id_valid;
  assign bus.halted         = halted;
  assign bus.pc_freeze      = halted;
  assign bus.cycle_count    = cycle_count;
  assign bus.instr_count    = instr_count;

endmodule

// File: tb/tb_fetch_decode_latch.sv
module tb_fetch_decode_latch;

  localparam int EW = 32 + 32 + 1 + 1 + 32 + 32;

  localparam logic [31:0] W_A  = 32'h2008_0001;
  localparam logic [31:0] W_B  = 32'h2009_0002;
  localparam logic [31:0] W_C  = 32'h0109_5020;
  localparam logic [31:0] W_D  = 32'hAC0A_0004;
  localparam logic [31:0] W_E  = 32'h8C0B_0004;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clock;
  logic reset;

  fetch_decode_if #(.CNT_WIDTH(32)) bus ();

  fetch_decode_latch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard state.
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs away from the edge, push the hand-computed expected
  // post-edge state, then wait for the edge.
  task automatic step(input logic rst, input logic en, input logic st, input logic fl,
                      input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] e_instr, input logic [31:0] e_npc,
                      input logic e_valid, input logic e_halt,
                      input logic [31:0] e_cyc, input logic [31:0] e_icnt);
    @(negedge clock);
    reset                   = rst;
    bus.enable              = en;
    bus.stall               = st;
    bus.flush               = fl;
    bus.instruction_address = addr;
    bus.instruction         = instr;
    exp_q.push_back({e_instr, e_npc, e_valid, e_halt, e_cyc, e_icnt});
    @(posedge clock);
  endtask

  // Monitor: a new payload appears after every edge; compare against the queue head.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("id_instruction", bus.id_instruction, e[EW-1 -: 32]);
        check("id_npc",         bus.id_npc,         e[EW-33 -: 32]);
        check("id_valid",       {31'd0, bus.id_valid},  {31'd0, e[65]});
        check("halted",         {31'd0, bus.halted},    {31'd0, e[64]});
        check("pc_freeze",      {31'd0, bus.pc_freeze}, {31'd0, e[64]});
        check("cycle_count",    bus.cycle_count,    e[63:32]);
        check("instr_count",    bus.instr_count,    e[31:0]);
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.instruction_address = '0;
    bus.instruction = '0;

    // Reset state.
    step(1,1,0,0, 32'd0, W_A,  32'd0, 32'd0, 0,0, 0,0);
    step(1,1,0,0, 32'd0, W_A,  32'd0, 32'd0, 0,0, 0,0);
    // Straight-line fetch A..D.
    step(0,1,0,0, 32'd0, W_A,  W_A, 32'd1, 1,0, 1,1);
    step(0,1,0,0, 32'd1, W_B,  W_B, 32'd2, 1,0, 2,2);
    step(0,1,0,0, 32'd2, W_C,  W_C, 32'd3, 1,0, 3,3);
    step(0,1,0,0, 32'd3, W_D,  W_D, 32'd4, 1,0, 4,4);
    // Load B, then stall three edges with C presented.
    step(0,1,0,0, 32'd1, W_B,  W_B, 32'd2, 1,0, 5,5);
    for (int i = 0; i < 3; i++)
      step(0,1,1,0, 32'd2, W_C, W_B, 32'd2, 1,0, 32'(6+i), 5);
    // Stall and flush on the same edge: flush wins.
    step(0,1,1,1, 32'd3, W_D,  32'd0, 32'd0, 0,0, 9,5);
    // Load D, then freeze for five edges while the inputs toggle.
    step(0,1,0,0, 32'd3, W_D,  W_D, 32'd4, 1,0, 10,6);
    for (int i = 0; i < 5; i++)
      step(0,0, i[0], i[1], 32'(i*7+100), (i == 2) ? HALT : 32'(i*32'h1111),
           W_D, 32'd4, 1,0, 10,6);
    step(0,1,0,0, 32'd4, W_E,  W_E, 32'd5, 1,0, 11,7);
    // A HALT word under flush is discarded.
    step(0,1,0,1, 32'd5, HALT, 32'd0, 32'd0, 0,0, 12,7);
    // The address successor wraps to zero.
    step(0,1,0,0, 32'hFFFF_FFFF, W_A, W_A, 32'd0, 1,0, 13,8);
    // Halt at address 7, then bubbles with frozen counters and held id_npc.
    step(0,1,0,0, 32'd7, HALT, HALT, 32'd8, 1,1, 14,9);
    step(0,1,0,0, 32'd8, W_A,  32'd0, 32'd8, 0,1, 14,9);
    step(0,1,1,1, 32'd9, W_B,  32'd0, 32'd8, 0,1, 14,9);
    step(0,0,0,0, 32'd9, W_B,  32'd0, 32'd8, 0,1, 14,9);
    // Reset while halted returns everything to the reset state.
    step(1,1,0,0, 32'd9, W_B,  32'd0, 32'd0, 0,0, 0,0);
    step(0,1,0,0, 32'd0, W_A,  W_A, 32'd1, 1,0, 1,1);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clock);
      wait_cycles++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
